mac_cfg_master: RTL
===================

# mac_cfg_master

Hardware configuration master that programs the MAC engine's register file without a core. It sits on the initiator side of the `hwpe_ctrl_intf_periph` port and performs the full job sequence: acquire a context, write the job registers from a descriptor, trigger, wait for the end-of-job event and report completion. It lets a DMA, test harness or sequencer offload MAC jobs autonomously.

## Interface
Parameters:
- `N_REGS`, 9: number of job registers written per job (4 pointers followed by NB_ITER, LEN_ITER, SHIFT_SIMPLEMUL, VECTSTRIDE, ITERSTRIDE2).
- `ID`, 10: width of the periph `id` field.
- `BACKOFF_CYCLES`, 16: idle cycles between failed acquire attempts.

Ports:
- `clk_i` input, 1: clock.
- `rst_ni` input, 1: reset, asynchronous and active-low.
- `clear_i` input, 1: synchronous soft clear.
- `start_i` input, 1: start-job pulse; sampled only in IDLE.
- `desc_i` input, `[N_REGS-1:0][31:0]`: job register values; latched on an accepted `start_i`.
- `evt_i` input, 1: end-of-job event from the engine (one bit of `evt_o`).
- `busy_o` output, 1: high in every state except IDLE.
- `done_o` output, 1: one-cycle pulse at job completion.
- `job_id_o` output, 8: job ID returned by acquire; valid while `done_o` is high and held afterwards.
- `retries_o` output, 16: number of failed acquires for the current or last job, saturating.
- `periph` `hwpe_ctrl_intf_periph.master`: `req`, `add`, `wen` (1 = read), `be`, `data`, `id` driven; `gnt`, `r_data`, `r_valid`, `r_id` sampled.

## Operation
- Register offsets are fixed:
  - TRIGGER 0x00
  - ACQUIRE 0x04
  - job registers start at 0x40, word `i` at 0x40+4·i
- `be` is always 4'hF. `id` is a constant 0.
- States and transitions:
  - **IDLE**: `start_i` latches `desc_i`, clears `retries_o` and moves to ACQ_REQ.
  - **ACQ_REQ**: read of ACQUIRE (`wen`=1, `add`=0x04). On `gnt`, move to ACQ_WAIT.
  - **ACQ_WAIT**: wait for `r_valid`.
    - If `r_data[31]`=1 (no free context): increment `retries_o` (saturate at 16'hFFFF) and move to BACKOFF.
    - Otherwise: store `r_data[7:0]` into the job-ID register and move to WR_REQ with index=0.
  - **BACKOFF**: count `BACKOFF_CYCLES` cycles, then move to ACQ_REQ.
  - **WR_REQ**: write `desc[index]` to 0x40+4·index (`wen`=0). On `gnt`, index++. After word N_REGS-1 is granted, move to TRIG_REQ.
  - **TRIG_REQ**: write 0 to TRIGGER. On `gnt`, move to RUN.
  - **RUN**: wait for `evt_i`, then move to DONE.
  - **DONE**: `done_o`=1 for one cycle, then IDLE.
- Handshake rules:
  - Once `req` is raised, `add`, `wen` and `data` stay stable until `gnt`.
  - At most one transaction is outstanding.
  - Responses to writes are not awaited. `r_valid` outside ACQ_WAIT is ignored.
- `evt_i` is ignored outside RUN. An `evt_i` in the same cycle as the trigger grant is not counted.
- `start_i` while busy is ignored. The latched descriptor is not disturbed.
- `clear_i` has priority over everything: next cycle is IDLE, `req`=0, index=0, backoff counter=0. `job_id_o` and `retries_o` keep their values.
- Reset: state IDLE; `busy_o`, `done_o`, `periph.req`, `add`, `data`, `wen` all 0; `job_id_o`=0; `retries_o`=0.

## Timing
- All outputs are registered. `busy_o` and `req` rise the cycle after an accepted `start_i`.
- Request/grant back-to-back: when `gnt` is high in cycle t, the next request is presented in cycle t+1 with `req` still high. There is no bubble between writes.
- Minimum sequence with `gnt` always high and `r_valid` one cycle after grant, `start_i` at cycle 0:
  - acquire request at 1, response at 2
  - writes at cycles 3 to 2+N_REGS
  - trigger at 3+N_REGS
  - RUN from 4+N_REGS
  - `done_o` one cycle after `evt_i` is sampled in RUN
- Backoff: after a failed response at cycle t, the next acquire `req` rises at cycle t+1+BACKOFF_CYCLES.

## Structure
- The offsets (TRIGGER, ACQUIRE, job base), the busy bit index (31) and the state enum belong in `mac_package`. `hwpe_ctrl_package` is reused for the interface.
- Single module. No sub-module; the backoff counter and write index are local counters.

## Test plan
- **Nominal job**: `gnt` tied 1, `r_valid`=1 one cycle after grant, acquire returns 0x00000001, `desc_i`={0x1000,0x2000,0x3000,0x4000,7,3,0x00050000,16,64}.
  - Nine writes to 0x40…0x60 with those values, then write 0 to 0x00.
  - `evt_i` 20 cycles later → `done_o` pulse, `job_id_o`=1, `retries_o`=0.
- **Busy context**: acquire returns 0xFFFFFFFF twice, then 0x00000000, with BACKOFF_CYCLES=16.
  - Acquire requests are spaced 17 cycles after each response; `retries_o`=2; `job_id_o`=0.
- **Grant stalls**: `gnt` low for 3 cycles on write 4.
  - `add`=0x50 and `data` are held stable; there are no duplicate or skipped writes.
- **Clear mid-write**: `clear_i` pulse during write 5.
  - Next cycle `req`=0 and the state is IDLE; a new `start_i` restarts from the acquire.
- **Spurious inputs**: `start_i` while in RUN, `evt_i` while in WR_REQ, and `r_valid` during writes.
  - No state change, no `done_o`.
- **Reset**: `rst_ni` asserted asynchronously mid-RUN.
  - All outputs are 0 immediately; the block is IDLE after release.

Source files
------------

// File: rtl/hwpe_ctrl_package.sv
// Shared constants for the HWPE control-port protocol.
package hwpe_ctrl_package;

  localparam int unsigned HWPE_CTRL_AW = 32;
  localparam int unsigned HWPE_CTRL_DW = 32;
  localparam int unsigned HWPE_CTRL_BW = HWPE_CTRL_DW / 8;

endpackage

// File: rtl/mac_package.sv
// MAC engine register map and the configuration-master state encoding.
package mac_package;

  localparam logic [31:0] MAC_REG_TRIGGER  = 32'h0000_0000;
  localparam logic [31:0] MAC_REG_ACQUIRE  = 32'h0000_0004;
  localparam logic [31:0] MAC_REG_JOB_BASE = 32'h0000_0040;
  localparam int unsigned MAC_BUSY_BIT     = 31;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACQ_REQ,
    ST_ACQ_WAIT,
    ST_BACKOFF,
    ST_WR_REQ,
    ST_TRIG_REQ,
    ST_RUN,
    ST_DONE
  } mac_cfg_state_e;

  function automatic logic [31:0] job_reg_addr(input logic [31:0] idx);
    return MAC_REG_JOB_BASE + (idx << 2);
  endfunction

endpackage

// File: rtl/hwpe_ctrl_intf_periph.sv
// Peripheral-style request/grant control port with a separate read response.
interface hwpe_ctrl_intf_periph
  import hwpe_ctrl_package::*;
#(
  parameter int unsigned ID_WIDTH = 8
);

  logic                      req;
  logic                      gnt;
  logic [HWPE_CTRL_AW-1:0]   add;
  logic                      wen;
  logic [HWPE_CTRL_BW-1:0]   be;
  logic [HWPE_CTRL_DW-1:0]   data;
  logic [ID_WIDTH-1:0]       id;
  logic [HWPE_CTRL_DW-1:0]   r_data;
  logic                      r_valid;
  logic [ID_WIDTH-1:0]       r_id;

  modport master (
    output req, add, wen, be, data, id,
    input  gnt, r_data, r_valid, r_id
  );

  modport slave (
    input  req, add, wen, be, data, id,
    output gnt, r_data, r_valid, r_id
  );

endinterface

// File: rtl/mac_cfg_master.sv
// Core-less configuration master: acquires a MAC context, writes the job
// registers from a latched descriptor, triggers, and waits for end-of-job.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | waiting for start_i; descriptor latched on accept
// ST_ACQ_REQ  | read of ACQUIRE presented, waiting for gnt
// ST_ACQ_WAIT | waiting for the acquire read response
// ST_BACKOFF  | no free context; idle BACKOFF_CYCLES before retrying
// ST_WR_REQ   | writing descriptor word idx to the job register bank
// ST_TRIG_REQ | write to TRIGGER presented, waiting for gnt
// ST_RUN      | engine running, waiting for evt_i
// ST_DONE     | one-cycle completion pulse
module mac_cfg_master
  import mac_package::*;
#(
  parameter int unsigned N_REGS         = 9,
  parameter int unsigned ID             = 10,
  parameter int unsigned BACKOFF_CYCLES = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   start_i,
  input  logic [N_REGS-1:0][31:0] desc_i,
  input  logic                   evt_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [7:0]             job_id_o,
  output logic [15:0]            retries_o,
  hwpe_ctrl_intf_periph.master   periph
);

  localparam int unsigned IW = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam int unsigned BW = (BACKOFF_CYCLES > 1) ? $clog2(BACKOFF_CYCLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_REGS - 1);
  localparam logic [BW-1:0] BO_LOAD  = BW'(BACKOFF_CYCLES - 1);

  mac_cfg_state_e         state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [BW-1:0]          bo_q, bo_d;
  logic [N_REGS-1:0][31:0] desc_q, desc_d;
  logic [7:0]             job_id_q, job_id_d;
  logic [15:0]            retries_q, retries_d;
  logic                   req_q, req_d;
  logic                   wen_q, wen_d;
  logic [31:0]            add_q, add_d;
  logic [31:0]            data_q, data_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      bo_q      <= '0;
      desc_q    <= '0;
      job_id_q  <= '0;
      retries_q <= '0;
      req_q     <= 1'b0;
      wen_q     <= 1'b0;
      add_q     <= '0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      bo_q      <= bo_d;
      desc_q    <= desc_d;
      job_id_q  <= job_id_d;
      retries_q <= retries_d;
      req_q     <= req_d;
      wen_q     <= wen_d;
      add_q     <= add_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    bo_d      = bo_q;
    desc_d    = desc_q;
    job_id_d  = job_id_q;
    retries_d = retries_q;

    if (clear_i) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      bo_d    = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            desc_d    = desc_i;
            retries_d = '0;
            state_d   = ST_ACQ_REQ;
          end
        end
        ST_ACQ_REQ: begin
          if (periph.gnt) state_d = ST_ACQ_WAIT;
        end
        ST_ACQ_WAIT: begin
          if (periph.r_valid) begin
            if (periph.r_data[MAC_BUSY_BIT]) begin
              if (retries_q != 16'hFFFF) retries_d = retries_q + 16'd1;
              if (BACKOFF_CYCLES == 0) begin
                state_d = ST_ACQ_REQ;
              end else begin
                bo_d    = BO_LOAD;
                state_d = ST_BACKOFF;
              end
            end else begin
              job_id_d = periph.r_data[7:0];
              idx_d    = '0;
              state_d  = ST_WR_REQ;
            end
          end
        end
        ST_BACKOFF: begin
          if (bo_q == '0) state_d = ST_ACQ_REQ;
          else            bo_d    = bo_q - 1'b1;
        end
        ST_WR_REQ: begin
          if (periph.gnt) begin
            if (idx_q == LAST_IDX) begin
              idx_d   = '0;
              state_d = ST_TRIG_REQ;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        ST_TRIG_REQ: begin
          // An event coinciding with the trigger grant belongs to a previous job.
          if (periph.gnt) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (evt_i) state_d = ST_DONE;
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Bus outputs are decoded from the next state so they come straight off flops.
    req_d  = (state_d == ST_ACQ_REQ) || (state_d == ST_WR_REQ) || (state_d == ST_TRIG_REQ);
    wen_d  = (state_d == ST_ACQ_REQ);
    add_d  = '0;
    data_d = '0;
    unique case (state_d)
      ST_ACQ_REQ:  add_d = MAC_REG_ACQUIRE;
      ST_WR_REQ: begin
        add_d  = job_reg_addr(32'(idx_d));
        data_d = desc_d[idx_d];
      end
      ST_TRIG_REQ: add_d = MAC_REG_TRIGGER;
      default: ;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  assign periph.req  = req_q;
  assign periph.wen  = wen_q;
  assign periph.add  = add_q;
  assign periph.data = data_q;
  assign periph.be   = 4'hF;
  assign periph.id   = {ID{1'b0}};

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign job_id_o  = job_id_q;
  assign retries_o = retries_q;

  logic unused_resp;
  assign unused_resp = ^{periph.r_data[30:8], periph.r_id};

endmodule
